uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered 8-bit UART transmitter, the transmit end of the serial link whose receive side feeds rx_byte.
//  Accepts bytes over ready/valid into a FIFO, serialises LSB-first as 8N1 (8E1 with parity) on pin.
//  Sits between the host-side byte producer (terminal/console logic) and the board TX pin.
// PARAMETERS
//  CLK    0   system clock in MHz; must be set
//  BAUD   0   baud rate in bit/s; must be set
//  DEPTH  16  FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1      system clock; all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  data_ready  out  1      FIFO can accept a byte this cycle
//  data_valid  in   1      producer offers data_byte
//  data_byte   in   8      byte to transmit
//  pin         out  1      serial output; idle high
//  busy        out  1      frame in progress or FIFO non-empty
//  fill        out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - DIVIDER = (CLK*1_000_000)/BAUD, integer truncation. $error at elaboration if DIVIDER < 2.
//  - Baud counter width is $clog2(DIVIDER). Every frame bit lasts exactly DIVIDER cycles.
//  - Reset values: pin=1, data_ready=0 while reset is high, busy=0, fill=0, FSM=IDLE, baud counter=0.
//  - data_ready = !full. It is registered from fill and does not depend on a same-cycle pop.
//  - Transfer occurs on an edge where data_valid && data_ready. The producer holds data_byte stable while valid && !ready.
//  - A valid with ready low is never dropped. Byte order is strictly preserved.
//  - FSM states: IDLE -> START -> DATA (8 bits, LSB first) -> [PARITY] -> STOP -> IDLE or START.
//  - IDLE: when the FIFO is non-empty, pop into the shift register and enter START.
//  - Latency: a byte pushed at edge N into an empty idle block drives pin low from edge N+2.
//  - STOP end: if the FIFO is non-empty, go directly to START with no idle gap. Otherwise go to IDLE with pin=1.
//  - Push and pop in the same cycle: fill is unchanged. Pointers wrap modulo DEPTH.
//  - Reset mid-frame: the frame is truncated, pin=1 on the next cycle, and FIFO contents are discarded.
//  - busy = (state != IDLE) || (fill != 0).
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//  - A PARITY state is inserted after DATA and drives even parity (XOR of the 8 data bits).
//  - Frame is 11 bits = 11*DIVIDER cycles.
//  UART_TX_PARITY_EN undefined:
//  - No PARITY state. Frame is 10 bits = 10*DIVIDER cycles.
// STRUCTURE
//  Package uart_pkg holds:
//  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
//  - localparam function uart_divider(clk_mhz, baud)
//  - UART_DATA_BITS = 8
//  Sub-module uart_tx_fifo:
//  - Synchronous DEPTH x 8 FIFO with push/pop, full/empty and fill.
//  - Internal read-before-write, no bypass path.
//  Top level holds the FSM, baud counter, bit index (0..7), shift register and parity register.
// TESTING
//  Bench settings: CLK=4, BAUD=1_000_000 (DIVIDER=4), DEPTH=16.
//  1. Assert reset 3 cycles:
//     -> pin=1, data_ready=0, busy=0, fill=0.
//     -> data_ready=1 on the first cycle after reset drops.
//  2. Push 0xA5 once:
//     -> pin low for 4 cycles from edge N+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles.
//     -> Frame totals 40 cycles. With parity: parity bit 0, 44 cycles.
//     -> busy falls after the stop bit.
//  3. Hold data_valid=1 with incrementing bytes:
//     -> exactly 17 accepted (16 in FIFO + 1 in shifter), then data_ready=0.
//     -> One more byte is accepted after each frame completes. All bytes arrive in order.
//  4. Push 0x00 then 0xFF back-to-back:
//     -> the 0xFF start bit immediately follows the 0x00 stop bit with zero idle cycles.
//  5. Pulse reset 1 cycle at cycle 12 of a 0x5A frame with 3 bytes queued:
//     -> pin=1 next cycle, fill=0, busy=0.
//     -> A later push of 0x3C produces one clean, complete frame.
//  6. Toggle data_valid randomly while the FIFO is full:
//     -> no byte is lost or duplicated.
//     -> The scoreboard decode of pin matches the pushed sequence over 200 bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and divider helper for the buffered UART transmitter
//   uart_tx_state_t : transmit FSM state encoding
//   UART_DATA_BITS  : data bits per frame
//   uart_divider()  : system clocks per serial bit
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Clocks per bit, truncated; a zero baud yields 0 so an unset parameter
    // reaches the elaboration check instead of a divide-by-zero.
    function automatic int uart_divider(input int clk_mhz, input int baud);
        if (baud <= 0) begin
            return 0;
        end
        return int'((longint'(clk_mhz) * 64'd1_000_000) / longint'(baud));
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - ready/valid byte channel from producer into the transmitter
//   data_valid : producer offers data_byte
//   data_byte  : byte to transmit
//   data_ready : transmitter can accept a byte this cycle
interface uart_tx_buffered_if;

    logic       data_valid;
    logic [7:0] data_byte;
    logic       data_ready;

    modport master (
        output data_valid,
        output data_byte,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data_byte,
        output data_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous DEPTH x WIDTH FIFO with occupancy count
//   clk, reset       : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data  : write request and data; ignored when full
//   pop, pop_data    : read request; pop_data shows the head entry combinationally
//   full, empty      : status flags derived from fill
//   fill             : current occupancy, 0..DEPTH
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (fill == (AW+1)'(DEPTH));
    assign empty    = (fill == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head is read from storage only; a byte written this cycle is not
    // visible until the next one, so there is no write-to-read bypass.
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined)
//   clk   : system clock, CLK MHz
//   reset : synchronous active-high reset; truncates any frame and empties the FIFO
//   bus   : ready/valid byte input (slave side of uart_tx_buffered_if)
//   pin   : serial output, idle high, LSB first
//   busy  : frame in progress or bytes queued
//   fill  : FIFO occupancy
// UART_TX_PARITY_EN : inserts an even-parity bit after the data bits
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK   = 0,
    parameter int BAUD  = 0,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_buffered_if.slave      bus,
    output logic                   pin,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int DIVIDER = uart_divider(CLK, BAUD);
    localparam int CNT_W   = (DIVIDER >= 2) ? $clog2(DIVIDER) : 1;

    if (DIVIDER < 2) begin : g_divider_check
        $error("uart_tx_buffered: CLK/BAUD give a bit period below 2 clocks");
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_tx_buffered: DEPTH must be a power of two and at least 2");
    end

    uart_tx_state_t               state, state_next;
    logic [CNT_W-1:0]             baud_cnt, baud_cnt_next;
    logic [2:0]                   bit_idx, bit_idx_next;
    logic [UART_DATA_BITS-1:0]    shift, shift_next;
`ifdef UART_TX_PARITY_EN
    logic                         parity, parity_next;
`endif
    logic                         pin_next;
    logic                         tick;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [UART_DATA_BITS-1:0]    pop_data;

    // Ready comes from registered occupancy only; a pop in the same cycle
    // does not open a slot early.
    assign bus.data_ready = !fifo_full && !reset;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.data_valid && bus.data_ready),
        .push_data (bus.data_byte),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .fill      (fill)
    );

    assign tick = (baud_cnt == CNT_W'(DIVIDER - 1));
    assign busy = (state != IDLE) || (fill != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
            pin      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_next;
`endif
            pin      <= pin_next;
        end
    end

    // pin is registered from the current state, so the line lags the FSM by
    // one clock; every state holds for DIVIDER clocks, so bit widths are exact.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity;
`endif
        pin_next      = 1'b1;
        pop           = 1'b0;

        if (state != IDLE) begin
            baud_cnt_next = tick ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                pin_next = 1'b1;
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    shift_next    = pop_data;
`ifdef UART_TX_PARITY_EN
                    parity_next   = ^pop_data;
`endif
                    baud_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                pin_next = 1'b0;
                if (tick) begin
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                pin_next = shift[0];
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                pin_next = parity;
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                pin_next = 1'b1;
                if (tick) begin
                    // Chain straight into the next start bit when data is queued.
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_next  = pop_data;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^pop_data;
`endif
                        state_next  = START;
                    end else begin
                        state_next  = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
